wra_dma_loader: RTL and testbench
=================================

# wra_dma_loader

Two-channel DMA read sequencer sitting directly upstream of the WRA core. It turns register-level start/size/base commands into the address and write-enable streams that load the core's input feature buffer (128-bit beats) and its filter buffer (512-bit beats). The feature/filter RAMs are combinational-read, so data returned for an address is valid in the same cycle. The block drives the core's `we`, `we_Gt` and `a_GtOutside` inputs directly.

## Interface
Parameters:
- `AW`, 16: width of addresses, sizes and the filter offset.

Ports:
- `HCLK`  in  1  sole clock; all state updates on its rising edge.
- `HRESETn`  in  1  reset, asynchronous, active-low.
- `feat_start`  in  1  one-cycle pulse that launches the feature channel (register bit 0).
- `feat_size`  in  AW  index of the last feature beat; the transfer is `feat_size+1` beats.
- `feat_addr`  out  AW  feature RAM read address, counting from 0.
- `feat_we`  out  1  feature beat valid; drives the core's `we`.
- `feat_busy`  out  1  feature channel is in RUN.
- `feat_done`  out  1  one-cycle pulse after the feature channel's last beat.
- `filt_start`  in  1  one-cycle pulse that launches the filter channel.
- `filt_base`  in  AW  filter RAM base address.
- `filt_size`  in  AW  index of the last filter beat, relative to the base.
- `filt_addr`  out  AW  filter RAM read address; runs from `base` to `base+size`.
- `filt_off`  out  AW  `filt_addr - base`; drives the core's `a_GtOutside`.
- `filt_we`  out  1  filter beat valid; drives the core's `we_Gt`.
- `filt_busy`  out  1  filter channel is in RUN.
- `filt_done`  out  1  one-cycle pulse after the filter channel's last beat.
- `err`  out  1  sticky flag: a start pulse arrived while that channel was busy.
- `err_clr`  in  1  synchronous clear for `err`.

## Operation
- The two channels are independent and may run concurrently. Each has its own FSM with states IDLE and RUN.
- IDLE → RUN when `*_start` is 1 at a clock edge. At that edge the channel:
  - latches size, and base for the filter channel (feature base is fixed at 0);
  - loads its counter with the base.
  - Later changes to the size/base inputs do not affect a running transfer.
- In RUN:
  - `*_we` is 1 and `*_addr` equals the counter.
  - The counter increments by 1 each cycle.
- RUN → IDLE on the edge after the cycle where `addr == base+size`.
  - `*_done` pulses 1 for the one cycle after that edge.
  - `*_addr` returns to the latched base and holds.
- `filt_off` = counter − latched base, computed modulo 2^AW.
- A size of 0 produces exactly one beat.
- `base+size` wraps modulo 2^AW. The address wraps through 0 and the transfer still ends after `size+1` beats, because termination uses a beat counter rather than an address compare.
- `*_start` while busy, including the last-beat cycle: ignored, and `err` is set to 1.
- `err_clr` and a new error in the same cycle: the error wins, so `err` stays 1.
- Reset, asserted asynchronously at any time including mid-transfer, forces:
  - all FSMs to IDLE;
  - all counters and latches to 0;
  - `feat_addr`, `feat_we`, `feat_busy`, `feat_done` to 0;
  - `filt_addr`, `filt_off`, `filt_we`, `filt_busy`, `filt_done` to 0;
  - `err` to 0.
- After reset is released, nothing starts until a new start pulse arrives.

## Timing
- Start sampled at edge N → first beat (`we=1`, `addr=base`) during cycle N+1.
- Beat k is presented in cycle N+1+k. The last beat is in cycle N+1+size.
- `done` is high in cycle N+2+size, with `busy=0` and `we=0`.
- A new start may be sampled at the edge that ends the last beat's cycle; it is ignored and raises `err`. It is accepted from cycle N+2+size onward, which gives back-to-back transfers with a one-cycle gap.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `WRA_DMA_FILTER_CH_EN` defined: the filter channel is built as described above.
- Not defined:
  - the filter FSM, counter and latches are removed;
  - `filt_addr`, `filt_off`, `filt_we`, `filt_busy`, `filt_done` are tied to 0;
  - `filt_start` never sets `err`;
  - the feature channel is unchanged.

## Test plan
- `feat_start` with `feat_size=195` → `feat_we` high for exactly 196 cycles, with `feat_addr` going 0..195. `feat_done` pulses once, one cycle after `addr=195`.
- `filt_start` with base=8, size=31 → `filt_addr` goes 8..39 and `filt_off` goes 0..31, 32 beats. Changing `filt_base` to 40 mid-run does not alter the sequence.
- Both channels started in the same cycle (feature size 6, filter base 40, size 159) → streams are independent with correct lengths, and each `done` pulses at its own N+2+size.
- `feat_start` again at beat 3 and again on the last-beat cycle → transfer unaffected, `err`=1 and stays 1 until `err_clr`. A start at N+2+size is accepted.
- Size 0 → a single beat, then `done`. Filter base=0xFFFE, size=3 → addresses FFFE, FFFF, 0000, 0001, `filt_off` 0..3, then `done`.
- `HRESETn` dropped mid-transfer, asynchronously between edges → outputs go to 0 immediately. After release there is no activity until the next start.

Source files
------------

// File: rtl/wra_dma_loader.sv
// Two-channel DMA read sequencer feeding the WRA feature (we) and filter (we_Gt) buffers.
// Define WRA_DMA_FILTER_CH_EN to build the filter channel; otherwise its outputs are tied to 0.

module wra_dma_ch #(
  parameter int AW = 16
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          i_start,
  input  logic [AW-1:0] i_base,
  input  logic [AW-1:0] i_size,
  output logic [AW-1:0] o_addr,
  output logic [AW-1:0] o_off,
  output logic          o_we,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err_evt
);
  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t        r_state, w_next;
  logic [AW-1:0] r_cnt, r_off, r_base, r_size;
  logic          r_done;
  logic          w_last;

  // r_off doubles as the beat counter, so address wrap through 0 cannot end a transfer early
  assign w_last = (r_off == r_size);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_next = S_RUN;
      S_RUN:   if (w_last)  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    o_we      = (r_state == S_RUN);
    o_busy    = (r_state == S_RUN);
    o_err_evt = i_start && (r_state == S_RUN);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_cnt  <= '0;
      r_off  <= '0;
      r_base <= '0;
      r_size <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_base <= i_base;
          r_size <= i_size;
          r_cnt  <= i_base;
          r_off  <= '0;
        end
        S_RUN: if (w_last) begin
          r_cnt  <= r_base;
          r_off  <= '0;
          r_done <= 1'b1;
        end else begin
          r_cnt  <= r_cnt + AW'(1);
          r_off  <= r_off + AW'(1);
        end
        default: ;
      endcase
    end
  end

  assign o_addr = r_cnt;
  assign o_off  = r_off;
  assign o_done = r_done;
endmodule

module wra_dma_loader #(
  parameter int AW = 16
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          feat_start,
  input  logic [AW-1:0] feat_size,
  output logic [AW-1:0] feat_addr,
  output logic          feat_we,
  output logic          feat_busy,
  output logic          feat_done,
  input  logic          filt_start,
  input  logic [AW-1:0] filt_base,
  input  logic [AW-1:0] filt_size,
  output logic [AW-1:0] filt_addr,
  output logic [AW-1:0] filt_off,
  output logic          filt_we,
  output logic          filt_busy,
  output logic          filt_done,
  output logic          err,
  input  logic          err_clr
);
  logic          w_feat_evt, w_filt_evt;
  logic [AW-1:0] w_unused_feat_off;
  logic          r_err;

  wra_dma_ch #(.AW(AW)) u_feat (
    .HCLK(HCLK), .HRESETn(HRESETn), .i_start(feat_start), .i_base('0), .i_size(feat_size),
    .o_addr(feat_addr), .o_off(w_unused_feat_off), .o_we(feat_we), .o_busy(feat_busy),
    .o_done(feat_done), .o_err_evt(w_feat_evt)
  );

`ifdef WRA_DMA_FILTER_CH_EN
  wra_dma_ch #(.AW(AW)) u_filt (
    .HCLK(HCLK), .HRESETn(HRESETn), .i_start(filt_start), .i_base(filt_base), .i_size(filt_size),
    .o_addr(filt_addr), .o_off(filt_off), .o_we(filt_we), .o_busy(filt_busy),
    .o_done(filt_done), .o_err_evt(w_filt_evt)
  );
`else
  logic w_unused_filt;
  assign w_unused_filt = ^{filt_start, filt_base, filt_size};
  assign filt_addr  = '0;
  assign filt_off   = '0;
  assign filt_we    = 1'b0;
  assign filt_busy  = 1'b0;
  assign filt_done  = 1'b0;
  assign w_filt_evt = 1'b0;
`endif

  // a new error beats a simultaneous clear
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn)                      r_err <= 1'b0;
    else if (w_feat_evt || w_filt_evt) r_err <= 1'b1;
    else if (err_clr)                  r_err <= 1'b0;
  end

  assign err = r_err;
endmodule

// File: tb/tb_wra_dma_loader.sv
// Bench for wra_dma_loader: cycle-indexed transfer model checked every cycle.
module tb_wra_dma_loader;
`ifdef WRA_DMA_FILTER_CH_EN
  localparam bit FILT_EN = 1'b1;
`else
  localparam bit FILT_EN = 1'b0;
`endif

  logic        HCLK = 1'b0, HRESETn = 1'b0;
  logic        feat_start = 1'b0, filt_start = 1'b0, err_clr = 1'b0;
  logic [15:0] feat_size = '0, filt_base = '0, filt_size = '0;
  logic [15:0] feat_addr, filt_addr, filt_off;
  logic        feat_we, feat_busy, feat_done, filt_we, filt_busy, filt_done, err;

  wra_dma_loader #(.AW(16)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .feat_start(feat_start), .feat_size(feat_size), .feat_addr(feat_addr),
    .feat_we(feat_we), .feat_busy(feat_busy), .feat_done(feat_done),
    .filt_start(filt_start), .filt_base(filt_base), .filt_size(filt_size),
    .filt_addr(filt_addr), .filt_off(filt_off), .filt_we(filt_we),
    .filt_busy(filt_busy), .filt_done(filt_done), .err(err), .err_clr(err_clr)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0, failures = 0;
  int ec = 0;  // posedges seen
  // model: a transfer accepted at edge S presents beat k after edge S+k, done after edge S+size+1
  bit fv = 0, lv = 0, m_err = 0;
  int fS = 0, fz = 0, lS = 0, lb = 0, lz = 0;

  logic [54:0] w_obs;
  assign w_obs = {feat_addr, feat_we, feat_busy, feat_done,
                  filt_addr, filt_off, filt_we, filt_busy, filt_done, err};

  function automatic logic [54:0] exp_vec();
    logic [15:0] fa, la, lo;
    logic fw, fd, lw, ld;
    fa = '0; fw = 0; la = 16'(lb); lo = '0; lw = 0;
    if (fv && ec >= fS && ec <= fS + fz) begin fw = 1; fa = 16'(ec - fS); end
    fd = fv && (ec == fS + fz + 1);
    if (lv && ec >= lS && ec <= lS + lz) begin lw = 1; lo = 16'(ec - lS); la = 16'(lb + ec - lS); end
    ld = lv && (ec == lS + lz + 1);
    return {fa, fw, fw, fd, la, lo, lw, lw, ld, m_err};
  endfunction

  function automatic void model_reset();
    fv = 0; lv = 0; fS = 0; fz = 0; lS = 0; lb = 0; lz = 0; m_err = 0;
  endfunction

  // drive one cycle of control inputs, advance the model over the coming edge, sample #1 after it
  task automatic tick(input logic fs, input logic ls, input logic clr);
    int  e;
    bit  fbusy, lbusy, evt;
    e = ec + 1;
    feat_start = fs; filt_start = ls; err_clr = clr;
    if (!HRESETn) model_reset();
    else begin
      fbusy = fv && (e - 1 >= fS) && (e - 1 <= fS + fz);
      lbusy = lv && (e - 1 >= lS) && (e - 1 <= lS + lz);
      evt = (fs && fbusy) || (FILT_EN && ls && lbusy);
      if (fs && !fbusy) begin fv = 1; fS = e; fz = int'(feat_size); end
      if (FILT_EN && ls && !lbusy) begin lv = 1; lS = e; lb = int'(filt_base); lz = int'(filt_size); end
      if (evt) m_err = 1; else if (clr) m_err = 0;
    end
    @(posedge HCLK); ec++; #1;
  endtask

  task automatic test_reset();
    #1; checks++;
    if (w_obs !== 55'd0) begin failures++; $display("FAIL reset_hold got=%h exp=0", w_obs); end
    repeat (2) tick(1, 1, 0);
    @(negedge HCLK); HRESETn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0); checks++;
      if (w_obs !== exp_vec()) begin failures++; $display("FAIL reset_idle cyc=%0d got=%h exp=%h", ec, w_obs, exp_vec()); end
    end
  endtask

  task automatic test_feat_long();
    feat_size = 16'd195;
    tick(1, 0, 0);
    for (int i = 0; i < 200; i++) begin
      checks++;
      if (w_obs !== exp_vec()) begin failures++; $display("FAIL feat_long cyc=%0d got=%h exp=%h", ec, w_obs, exp_vec()); end
      feat_size = 16'($urandom);
      tick(0, 0, 0);
    end
  endtask

  task automatic test_filt();
    filt_base = 16'd8; filt_size = 16'd31;
    tick(0, 1, 0);
    for (int i = 0; i < 36; i++) begin
      checks++;
      if (w_obs !== exp_vec()) begin failures++; $display("FAIL filt_seq cyc=%0d got=%h exp=%h", ec, w_obs, exp_vec()); end
      if (i == 10) filt_base = 16'd40;
      tick(0, 0, 0);
    end
  endtask

  task automatic test_concurrent();
    feat_size = 16'd6; filt_base = 16'd40; filt_size = 16'd159;
    tick(1, 1, 0);
    for (int i = 0; i < 164; i++) begin
      checks++;
      if (w_obs !== exp_vec()) begin failures++; $display("FAIL concurrent cyc=%0d got=%h exp=%h", ec, w_obs, exp_vec()); end
      tick(0, 0, 0);
    end
  endtask

  task automatic test_err();
    feat_size = 16'd10;
    tick(1, 0, 0);                    // after this, beat 0 is on the outputs
    for (int i = 1; i <= 14; i++) begin
      // start during beat 3 and during the last beat (both ignored), then during done (accepted)
      tick((i == 4 || i == 11 || i == 12), 0, 0); checks++;
      if (w_obs !== exp_vec()) begin failures++; $display("FAIL err_busy cyc=%0d got=%h exp=%h", ec, w_obs, exp_vec()); end
    end
    tick(1, 0, 1); checks++;          // fresh error together with clear: error wins
    if (w_obs !== exp_vec()) begin failures++; $display("FAIL err_vs_clr cyc=%0d got=%h exp=%h", ec, w_obs, exp_vec()); end
    repeat (8) tick(0, 0, 0);
    tick(0, 0, 1); checks++;
    if (w_obs !== exp_vec()) begin failures++; $display("FAIL err_clear cyc=%0d got=%h exp=%h", ec, w_obs, exp_vec()); end
  endtask

  task automatic test_wrap();
    feat_size = 16'd0; filt_base = 16'hFFFE; filt_size = 16'd3;
    tick(1, 1, 0);
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (w_obs !== exp_vec()) begin failures++; $display("FAIL wrap_size0 cyc=%0d got=%h exp=%h", ec, w_obs, exp_vec()); end
      tick(0, 0, 0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      feat_size = 16'($urandom_range(0, 12));
      filt_base = 16'($urandom);
      filt_size = 16'($urandom_range(0, 12));
      tick($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 9) == 0);
      checks++;
      if (w_obs !== exp_vec()) begin failures++; $display("FAIL random cyc=%0d got=%h exp=%h", ec, w_obs, exp_vec()); end
    end
  endtask

  task automatic test_async_reset();
    feat_size = 16'd50; filt_base = 16'd100; filt_size = 16'd50;
    repeat (20) tick(0, 0, 0);
    tick(1, 1, 0);
    repeat (5) tick(0, 0, 0);
    tick(1, 0, 0);                    // sets err so the reset has something to clear
    @(negedge HCLK); #2; HRESETn = 1'b0; model_reset(); #1;
    checks++;
    if (w_obs !== 55'd0) begin failures++; $display("FAIL async_reset got=%h exp=0", w_obs); end
    repeat (2) tick(0, 0, 0);
    @(negedge HCLK); #1; HRESETn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(0, 0, 0); checks++;
      if (w_obs !== exp_vec()) begin failures++; $display("FAIL post_reset cyc=%0d got=%h exp=%h", ec, w_obs, exp_vec()); end
    end
  endtask

  initial begin
    test_reset();
    test_feat_long();
    test_filt();
    test_concurrent();
    test_err();
    test_wrap();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
